// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_seq: registered, multi-cycle WIDTH-bit ALU with a start/busy/done
// handshake. This block sits between the operand register file and the
// writeback stage.
//
// Operands and the opcode are captured when a start is accepted in IDLE.
// Single-cycle ops go IDLE -> EXEC -> DONE. MUL goes IDLE -> MUL (WIDTH
// shift-add steps) -> DONE. The result and flags are written only on the
// edge that enters DONE, and they are held until the next DONE.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (wins over start)
//   start          request, sampled only while busy=0
//   ALUctl[2:0]    opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLT, 6 MUL, 7 SHL
//   A, B           WIDTH-bit operands, sampled with start
//   busy           high in EXEC, MUL and DONE
//   done           one-cycle pulse while in DONE
//   ALUOut         registered result
//   ZF, CF, SF, OF registered zero, carry/borrow, sign, signed-overflow flags
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             ZF,
  output logic             CF,
  output logic             SF,
  output logic             OF
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_MUL = 3'd6,
    OP_SHL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [WIDTH-1:0]       a_q, b_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     prod_q;
  logic [2*WIDTH-1:0]     mcand_q;   // multiplicand, shifted left one bit per step
  logic [WIDTH-1:0]       mplier_q;  // multiplier, shifted right one bit per step
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   zf_q, cf_q, sf_q, of_q;
  logic                   zf_d, cf_d, sf_d, of_d;

  logic                   mul_last;
  logic [2*WIDTH-1:0]     prod_step;
  logic [WIDTH:0]         sum, diff;
  logic [WIDTH-1:0]       shamt;
  logic [2*WIDTH-1:0]     shl_wide;
  logic [WIDTH-1:0]       ex_res;
  logic                   ex_cf, ex_of;

  assign mul_last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (op_e'(ALUctl) == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, working only from the captured operands
  // ---------------------------------------------------------------------------
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};   // bit WIDTH is the borrow

  // Shifting a zero-extended copy leaves the last bit shifted out at bit WIDTH,
  // which is naturally 0 for a shift amount of 0.
  assign shamt    = WIDTH'(32'(b_q) % WIDTH);
  assign shl_wide = {{WIDTH{1'b0}}, a_q} << shamt;

  always_comb begin
    ex_res = '0;
    ex_cf  = 1'b0;
    ex_of  = 1'b0;
    unique case (op_q)
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_ADD: begin
        ex_res = sum[WIDTH-1:0];
        ex_cf  = sum[WIDTH];
        ex_of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res = diff[WIDTH-1:0];
        ex_cf  = diff[WIDTH];
        ex_of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: ex_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SHL: begin
        ex_res = shl_wide[WIDTH-1:0];
        ex_cf  = shl_wide[WIDTH];
      end
      default: ex_res = '0;  // MUL never reaches EXEC
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result/flag update: only on the edge that enters DONE
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    if (state_q == S_EXEC) begin
      result_d = ex_res;
      cf_d     = ex_cf;
      of_d     = ex_of;
      zf_d     = (ex_res == '0);
      sf_d     = ex_res[WIDTH-1];
    end else if (state_q == S_MUL && mul_last) begin
      result_d = prod_step[WIDTH-1:0];
      cf_d     = |prod_step[2*WIDTH-1:WIDTH];
      of_d     = 1'b0;
      zf_d     = (prod_step[WIDTH-1:0] == '0);
      sf_d     = prod_step[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      zf_q     <= 1'b1;   // consistent with result_q == 0
      cf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
      if (state_q == S_IDLE && start) begin
        op_q     <= op_e'(ALUctl);
        a_q      <= A;
        b_q      <= B;
        cnt_q    <= '0;
        prod_q   <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
      end else if (state_q == S_MUL) begin
        prod_q   <= prod_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign ALUOut = result_q;
  assign ZF     = zf_q;
  assign CF     = cf_q;
  assign SF     = sf_q;
  assign OF     = of_q;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_seq: directed, table-driven bench for alu_seq at WIDTH=8, plus
// hand-written sequences for start-while-busy, mid-multiply reset, and
// reset/start collision. Inputs change on the falling edge; outputs are
// sampled on the falling edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   ALUctl;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] ALUOut;
  logic         ZF, CF, SF, OF;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ALUctl (ALUctl),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .ALUOut (ALUOut),
    .ZF     (ZF),
    .CF     (CF),
    .SF     (SF),
    .OF     (OF)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zf;
    logic         cf;
    logic         sf;
    logic         of;
    string        name;
  } vec_t;

  vec_t vecs[16];

  // Issue one operation, then perturb the inputs to prove they were latched.
  // Counting starts in the cycle after the accepting edge; done is expected
  // one cycle later for single-cycle ops and W cycles later for MUL.
  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    start = 1'b1; ALUctl = v.op; A = v.a; B = v.b;
    @(negedge clk);
    start = 1'b0; ALUctl = ~v.op; A = ~v.a; B = ~v.b;
    check({v.name, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 2 * W + 8) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, lat, (v.op == 3'd6) ? W : 1);
    check({v.name, " result"}, 32'(ALUOut), 32'(v.res));
    check({v.name, " flags ZCSO"}, {28'd0, ZF, CF, SF, OF}, {28'd0, v.zf, v.cf, v.sf, v.of});
    @(negedge clk);
    check({v.name, " done pulse width"}, {30'd0, busy, done}, 32'd0);
    check({v.name, " result held"}, 32'(ALUOut), 32'(v.res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;

    //              op     a      b      res    zf cf sf of name
    vecs[0]  = '{3'd2, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, "add 7f+01"};
    vecs[1]  = '{3'd3, 8'h00, 8'h01, 8'hFF, 0, 1, 1, 0, "sub 00-01"};
    vecs[2]  = '{3'd5, 8'h80, 8'h01, 8'h01, 0, 0, 0, 0, "slt 80<01"};
    vecs[3]  = '{3'd6, 8'h0F, 8'h11, 8'hFF, 0, 0, 1, 0, "mul 0f*11"};
    vecs[4]  = '{3'd6, 8'h10, 8'h10, 8'h00, 1, 1, 0, 0, "mul 10*10"};
    vecs[5]  = '{3'd7, 8'h81, 8'h09, 8'h02, 0, 1, 0, 0, "shl 81<<9"};
    vecs[6]  = '{3'd7, 8'h81, 8'h08, 8'h81, 0, 0, 1, 0, "shl 81<<8"};
    vecs[7]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, "and f0&3c"};
    vecs[8]  = '{3'd1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, "or 00|00"};
    vecs[9]  = '{3'd4, 8'hA5, 8'h0F, 8'hAA, 0, 0, 1, 0, "xor a5^0f"};
    vecs[10] = '{3'd2, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, "add ff+01"};
    vecs[11] = '{3'd3, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, "sub 80-01"};
    vecs[12] = '{3'd5, 8'h01, 8'h80, 8'h00, 1, 0, 0, 0, "slt 01<80"};
    vecs[13] = '{3'd6, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 0, "mul ff*ff"};
    vecs[14] = '{3'd7, 8'h01, 8'h07, 8'h80, 0, 0, 1, 0, "shl 01<<7"};
    vecs[15] = '{3'd3, 8'h7F, 8'hFF, 8'h80, 0, 1, 1, 1, "sub 7f-ff"};

    reset = 1'b1; start = 1'b0; ALUctl = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset result", 32'(ALUOut), 32'd0);
    check("reset flags ZCSO", {28'd0, ZF, CF, SF, OF}, 32'b1000);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Start pulsed during a multiply must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; ALUctl = 3'd6; A = 8'h0F; B = 8'h11;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        start = 1'b1; ALUctl = 3'd2; A = 8'h01; B = 8'h02;
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("busy-start done count", done_cnt, 1);
    check("busy-start mul result", 32'(ALUOut), 32'hFF);
    check("busy-start mul flags ZCSO", {28'd0, ZF, CF, SF, OF}, 32'b0010);

    // Reset while the multiply counter is at 4 aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; ALUctl = 3'd6; A = 8'h10; B = 8'h10;
    @(negedge clk);              // counter = 0
    start = 1'b0;
    repeat (4) @(negedge clk);   // counter = 4
    check("mid-mul busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort result", 32'(ALUOut), 32'd0);
    check("abort flags ZCSO", {28'd0, ZF, CF, SF, OF}, 32'b1000);
    reset = 1'b0;
    start = 1'b1; ALUctl = 3'd2; A = 8'h03; B = 8'h04;
    @(negedge clk);
    start = 1'b0;
    check("post-abort accept busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("post-abort done", 32'(done), 32'd1);
    check("post-abort result", 32'(ALUOut), 32'h07);
    @(negedge clk);

    // Reset and start together: reset wins and nothing is accepted.
    reset = 1'b1; start = 1'b1; ALUctl = 3'd1; A = 8'h55; B = 8'h0A;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset+start busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("reset+start no done", {30'd0, busy, done}, 32'd0);
    check("reset+start result", 32'(ALUOut), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. It performs WIDTH-bit logic, arithmetic, compare, shift and multi-cycle multiply operations under a start/busy/done handshake, and holds registered result and flags. It sits between the operand register file and the writeback stage. Multiply is an iterative shift-add, so datapath area stays small.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock; the block uses only this clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALUctl  input  3  opcode, sampled with start
- A, B  input  WIDTH  operands, sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; ALUOut and flags are valid and updated in that cycle
- ALUOut  output  WIDTH  result, held until the next done
- ZF, CF, SF, OF  output  1 each  zero, carry/borrow, sign, signed-overflow flags, held with ALUOut

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 XOR, 5 SLT (signed A<B gives 1, else 0), 6 MUL (unsigned, low WIDTH bits kept), 7 SHL (A << B mod WIDTH).
- Start acceptance: on accept, A, B and ALUctl are latched into internal registers. Later input changes have no effect on the operation in progress.
- FSM states:
  - IDLE: start=1 with op≠6 goes to EXEC; start=1 with op=6 goes to MUL with cnt=0.
  - EXEC: computes the result; goes to DONE.
  - MUL: one shift-add step per cycle; cnt increments each cycle; after cnt=WIDTH-1 goes to DONE.
  - DONE: done=1, outputs registered; goes to IDLE.
- busy=1 in EXEC, MUL and DONE. A start asserted while busy=1 is ignored and is not queued. Back-to-back operation: a start in the cycle after done is accepted.
- Arithmetic uses an internal WIDTH+1-bit sum. For ADD, CF = bit WIDTH. For SUB, CF = borrow, which equals unsigned A<B.
- OF:
  - ADD: operand sign bits equal and result sign bit differs.
  - SUB: operand sign bits differ and result sign bit differs from A's.
  - All other opcodes: OF=0.
- MUL: the product accumulates in a 2*WIDTH-bit register. ALUOut = low WIDTH bits. CF=1 if any of the high WIDTH bits is nonzero.
- SHL: shift amount = B mod WIDTH. CF = last bit shifted out; CF=0 when the amount is 0.
- AND, OR, XOR, SLT: CF=0.
- ZF = (ALUOut==0). SF = ALUOut[WIDTH-1]. Both apply to every opcode.
- Undefined inputs are not supported; every opcode value is defined.

## Timing
- Reset (synchronous, takes effect at the clk edge): FSM goes to IDLE.
  - All outputs go to 0: busy, done, ALUOut, ZF, CF, SF, OF.
  - Exception: ZF is reset to 1, consistent with ALUOut=0.
  - cnt and the product register clear.
- Reset mid-operation: aborts immediately. No done pulse follows; flags return to their reset values.
- Latency, with start accepted at edge 0:
  - Ops 0-5 and 7: done=1 in the cycle after edge 2 (EXEC, then DONE).
  - Op 6: done=1 in the cycle after edge WIDTH+1.
- Throughput: non-MUL ops take 3 cycles each, including the IDLE acceptance cycle. MUL takes WIDTH+2 cycles.
- ALUOut and flags change only at the edge that enters DONE; they are stable at all other times.
- start and reset asserted together: reset wins.

## Test plan
- Reset, then WIDTH=8, ADD A=0x7F B=0x01 -> done 2 cycles after accept; ALUOut=0x80, SF=1, OF=1, CF=0, ZF=0.
- SUB A=0x00 B=0x01 -> ALUOut=0xFF, CF=1, SF=1, OF=0. Then SLT A=0x80 B=0x01 -> ALUOut=0x01, SF=0.
- MUL A=0x0F B=0x11 -> done at edge 9; ALUOut=0xFF, CF=0. MUL A=0x10 B=0x10 -> ALUOut=0x00, ZF=1, CF=1.
- SHL A=0x81 B=0x09 (amount 1) -> ALUOut=0x02, CF=1. SHL A=0x81 B=0x08 (amount 0) -> ALUOut=0x81, CF=0.
- During MUL, pulse start with an ADD and change A and B -> ignored; MUL result unchanged; exactly one done pulse.
- Assert reset at MUL cnt=4 -> next cycle busy=0, ALUOut=0, ZF=1; no done pulse. A start in the following cycle is accepted normally.
